elastic_buffer: RTL

Parametrised successor to the single-entry skid stage. It is a DEPTH-entry valid/ready elastic buffer with a selectable fall-through or registered-output mode, synchronous flush, and an occupancy output. It sits between JESD204B link-layer stages, such as lane deframer to transport mapper, to absorb backpressure bursts longer than one beat.

---
 rtl/jesd_buf_pkg.sv | 14 +
 rtl/elastic_buffer_ptr.sv | 23 ++
 rtl/elastic_buffer.sv | 86 ++++++++
 3 files changed

// File: rtl/jesd_buf_pkg.sv
// Sizing helpers shared by the elastic buffer and its pointer counters.
package jesd_buf_pkg;

    // Width needed to hold an occupancy of 0..depth.
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Pointer width; a single-entry buffer still gets a 1-bit pointer.
    function automatic int ptr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/elastic_buffer_ptr.sv
// Circular pointer that wraps at DEPTH-1, so any DEPTH (not just 2^n) works.
module buf_ptr
    import jesd_buf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = ptr_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    // Advance on inc, wrapping explicitly at the last entry.
    always_ff @(posedge clk) begin
        if (rst || clr)
            ptr <= '0;
        else if (inc)
            ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end

endmodule

// File: rtl/elastic_buffer.sv
// DEPTH-entry valid/ready elastic buffer with optional empty-buffer bypass,
// synchronous flush and a registered occupancy output.
module elastic_buffer
    import jesd_buf_pkg::*;
#(
    parameter int W        = 16,
    parameter int DEPTH    = 4,
    parameter int FALLTHRU = 1,
    parameter int LW       = lvl_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          upstream_val,
    output logic          upstream_rdy,
    input  logic [W-1:0]  upstream_dat,
    output logic          downstream_val,
    input  logic          downstream_rdy,
    output logic [W-1:0]  downstream_dat,
    output logic [LW-1:0] level
);

    localparam int PW = ptr_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [LW-1:0] count;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic          live, full, empty;
    logic          up_xfer, dn_xfer, bypass, push, pop;

    assign live  = !rst && !flush;
    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);

    // A full buffer may still accept when its head leaves in the same cycle.
    assign upstream_rdy = live && (!full || downstream_rdy);

    generate
        if (FALLTHRU != 0) begin : g_ft
            // Empty buffer presents the incoming beat directly.
            assign downstream_val = live && (!empty || upstream_val);
            assign downstream_dat = empty ? upstream_dat : mem[rd_ptr];
            assign bypass         = empty && up_xfer && dn_xfer;
        end else begin : g_reg
            // Output comes only from storage: no upstream-to-downstream comb path.
            assign downstream_val = live && !empty;
            assign downstream_dat = mem[rd_ptr];
            assign bypass         = 1'b0;
        end
    endgenerate

    assign up_xfer = upstream_val && upstream_rdy;
    assign dn_xfer = downstream_val && downstream_rdy;
    assign push    = up_xfer && !bypass;
    assign pop     = dn_xfer && !empty;
    assign level   = count;

    buf_ptr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ptr (
        .clk (clk), .rst (rst), .clr (flush), .inc (pop),  .ptr (rd_ptr)
    );

    buf_ptr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ptr (
        .clk (clk), .rst (rst), .clr (flush), .inc (push), .ptr (wr_ptr)
    );

    // Occupancy: +1 on push only, -1 on pop only, held otherwise.
    always_ff @(posedge clk) begin
        if (rst || flush)
            count <= '0;
        else if (push && !pop)
            count <= count + 1'b1;
        else if (pop && !push)
            count <= count - 1'b1;
    end

    // Storage write; reset clears contents, flush leaves them stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr] <= upstream_dat;
        end
    end

endmodule
